// File: rtl/efi_pkg.sv
// Shared constants, FSM state type and small helpers for the EFI core.
//   TEETH_TOTAL / TEETH_MISSING : 60-2 trigger wheel geometry
//   LAST_TOOTH                  : highest tooth index (58 present teeth, 0..57)
//   HALF_REV                    : tooth offset of the second cylinder pair
//   sync_state_e                : crank decoder state {NO_SYNC, SYNCED}
package efi_pkg;
  localparam int TEETH_TOTAL   = 60;
  localparam int TEETH_MISSING = 2;
  localparam int TEETH_PRESENT = TEETH_TOTAL - TEETH_MISSING;
  localparam int LAST_TOOTH    = 57;
  localparam int HALF_REV      = 30;
  localparam int IDX_W         = 6;

  typedef enum logic {NO_SYNC = 1'b0, SYNCED = 1'b1} sync_state_e;

  // Tooth index wrapped into the 58-slot present-tooth space.
  function automatic logic [IDX_W-1:0] tooth_pos(input int t);
    int m;
    m = t % TEETH_PRESENT;
    if (m < 0) m = m + TEETH_PRESENT;
    return IDX_W'(m);
  endfunction

  // Set/clear update for an output latch; clear dominates.
  function automatic logic set_clr(input logic cur, input logic set, input logic clr);
    return clr ? 1'b0 : (set ? 1'b1 : cur);
  endfunction
endpackage

// File: rtl/efi_crank_gen.sv
// Synthetic 60-2 crank pattern for bench-top running without a wheel.
// Ports:
//   clk       in  core clock
//   reset     in  asynchronous active-low reset
//   crank_out out 60-2 pattern, TOOTH_CYCLES clk per tooth, 50% duty,
//                 two trailing tooth slots held low
module efi_crank_gen
  import efi_pkg::*;
#(
  parameter int TOOTH_CYCLES = 800
) (
  input  logic clk,
  input  logic reset,
  output logic crank_out
);
  localparam int PH_W = $clog2(TOOTH_CYCLES);

  logic [PH_W-1:0]  phase_q;
  logic [IDX_W-1:0] slot_q;
  logic             out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      slot_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      if (phase_q == PH_W'(TOOTH_CYCLES - 1)) begin
        phase_q <= '0;
        slot_q  <= (slot_q == IDX_W'(TEETH_TOTAL - 1)) ? '0 : slot_q + IDX_W'(1);
      end else begin
        phase_q <= phase_q + PH_W'(1);
      end
      out_q <= (phase_q < PH_W'(TOOTH_CYCLES / 2)) && (slot_q < IDX_W'(TEETH_PRESENT));
    end
  end

  assign crank_out = out_q;
endmodule

// File: rtl/efi_main_core.sv
// Engine-control core: 60-2 crank decoder plus tooth-indexed coil and
// batch-fire injector scheduler.
// Ports:
//   clk              in  core clock (2 MHz nominal)
//   reset            in  asynchronous active-low reset
//   vrin             in  conditioned crank signal, asynchronous to clk
//   distributor_mode in  1: single coil on ign_a every half rev; 0: wasted spark
//   fake_crank       in  (EFI_CRANK_GEN_EN only) decode the internal generator
//   ign_a..ign_d     out coil dwell (high = charging, falling edge = spark)
//   inj_a, inj_b     out injector open
//   synced           out decoder locked to the wheel
// Build option: define EFI_CRANK_GEN_EN to add fake_crank and efi_crank_gen.
module efi_main_core
  import efi_pkg::*;
#(
  parameter int PERIOD_W        = 21,
  parameter int STALL_CYCLES    = 2_000_000,
  parameter int IGN_FIRE_TOOTH  = 10,
  parameter int IGN_DWELL_TEETH = 3,
  parameter int INJ_TOOTH       = 0,
  parameter int INJ_PW_CYCLES   = 6000
) (
  input  logic clk,
  input  logic reset,
  input  logic vrin,
  input  logic distributor_mode,
`ifdef EFI_CRANK_GEN_EN
  input  logic fake_crank,
`endif
  output logic ign_a,
  output logic ign_b,
  output logic ign_c,
  output logic ign_d,
  output logic inj_a,
  output logic inj_b,
  output logic synced
);
  localparam int STAGES = 1;
  localparam int INJ_W  = $clog2(INJ_PW_CYCLES + 1);

  localparam logic [IDX_W-1:0] FIRE_A   = tooth_pos(IGN_FIRE_TOOTH);
  localparam logic [IDX_W-1:0] DWELL_A  = tooth_pos(IGN_FIRE_TOOTH - IGN_DWELL_TEETH);
  localparam logic [IDX_W-1:0] FIRE_B   = tooth_pos(IGN_FIRE_TOOTH + HALF_REV);
  localparam logic [IDX_W-1:0] DWELL_B  = tooth_pos(IGN_FIRE_TOOTH - IGN_DWELL_TEETH + HALF_REV);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(LAST_TOOTH);
  localparam logic [1:0][IDX_W-1:0] INJ_POS = {tooth_pos(INJ_TOOTH + HALF_REV), tooth_pos(INJ_TOOTH)};
  localparam logic [PERIOD_W-1:0] STALL_LIM = PERIOD_W'(STALL_CYCLES);
  localparam logic [INJ_W-1:0]    INJ_PW    = INJ_W'(INJ_PW_CYCLES);

  // ---------------- tooth edge detect ----------------
  logic vr_s1_q, vr_s2_q, src_prev_q, tooth_src, rise;
  // [0]: tooth strobe seen by the decoder, [1]: same event seen by the scheduler
  logic [STAGES:0] vld_pipe_q;

`ifdef EFI_CRANK_GEN_EN
  logic gen_crank;
  efi_crank_gen u_gen (.clk(clk), .reset(reset), .crank_out(gen_crank));
  assign tooth_src = fake_crank ? gen_crank : vr_s2_q;
`else
  assign tooth_src = vr_s2_q;
`endif

  assign rise = tooth_src & ~src_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vr_s1_q    <= 1'b0;
      vr_s2_q    <= 1'b0;
      src_prev_q <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      vr_s1_q    <= vrin;
      vr_s2_q    <= vr_s1_q;
      src_prev_q <= tooth_src;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], rise};
    end
  end

  // ---------------- period measurement / gap test ----------------
  logic                tooth, evt, stall, is_gap, gap_ok;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, pprev_q;
  logic [PERIOD_W:0]   gap_thr;
  logic [1:0]          ev_seen_q, ev_seen_d;

  assign tooth   = vld_pipe_q[0];
  assign evt     = vld_pipe_q[STAGES];
  assign stall   = (cnt_q >= STALL_LIM);
  assign gap_thr = {1'b0, pprev_q} + {2'b00, pprev_q[PERIOD_W-1:1]};
  assign is_gap  = ({1'b0, cnt_q} > gap_thr);
  // Two prior events are needed before both P and Pprev are real periods.
  assign gap_ok  = (ev_seen_q == 2'd2);

  always_comb begin
    cnt_d     = cnt_q;
    ev_seen_d = ev_seen_q;
    if (tooth)              cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + PERIOD_W'(1);
    if (stall)              ev_seen_d = 2'd0;
    else if (tooth && ev_seen_q != 2'd2) ev_seen_d = ev_seen_q + 2'd1;
  end

  // ---------------- sync FSM ----------------
  sync_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (stall) begin
      state_d = NO_SYNC;
      idx_d   = '0;
    end else if (tooth) begin
      unique case (state_q)
        NO_SYNC: begin
          if (gap_ok && is_gap) begin
            state_d = SYNCED;
            idx_d   = '0;
          end
        end
        SYNCED: begin
          // Only the expected gap after tooth 57 keeps lock; a gap anywhere
          // else, or a missing gap, means we lost the wheel.
          if (is_gap != (idx_q == LAST_POS)) begin
            state_d = NO_SYNC;
            idx_d   = '0;
          end else if (is_gap) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = NO_SYNC;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pprev_q   <= '0;
      ev_seen_q <= '0;
      state_q   <= NO_SYNC;
      idx_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ev_seen_q <= ev_seen_d;
      if (tooth) pprev_q <= cnt_q;
      state_q   <= state_d;
      idx_q     <= idx_d;
    end
  end

  logic is_synced;
  assign is_synced = (state_q == SYNCED);
  assign synced    = is_synced;

  // ---------------- ignition scheduler ----------------
  logic dmode_q;
  logic ign_a_q, ign_b_q, ign_c_q, ign_d_q;
  logic ign_a_d, ign_b_d, ign_c_d, ign_d_d;
  logic at_da, at_db, at_fa, at_fb;

  assign at_da = (idx_q == DWELL_A);
  assign at_db = (idx_q == DWELL_B);
  assign at_fa = (idx_q == FIRE_A);
  assign at_fb = (idx_q == FIRE_B);

  always_comb begin
    ign_a_d = ign_a_q;
    ign_b_d = ign_b_q;
    ign_c_d = ign_c_q;
    ign_d_d = ign_d_q;
    if (!is_synced) begin
      ign_a_d = 1'b0;
      ign_b_d = 1'b0;
      ign_c_d = 1'b0;
      ign_d_d = 1'b0;
    end else if (evt) begin
      // ign_a clears at both fire points so a dwell begun in distributor
      // mode still ends at its own spark after a mode change.
      ign_a_d = set_clr(ign_a_q, at_da | (dmode_q & at_db), at_fa | at_fb);
      ign_b_d = set_clr(ign_b_q, ~dmode_q & at_db, dmode_q | at_fb);
      ign_c_d = set_clr(ign_c_q, ~dmode_q & at_da, dmode_q | at_fa | at_fb);
      ign_d_d = set_clr(ign_d_q, ~dmode_q & at_db, dmode_q | at_fb);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmode_q <= 1'b0;
      ign_a_q <= 1'b0;
      ign_b_q <= 1'b0;
      ign_c_q <= 1'b0;
      ign_d_q <= 1'b0;
    end else begin
      dmode_q <= distributor_mode;
      ign_a_q <= ign_a_d;
      ign_b_q <= ign_b_d;
      ign_c_q <= ign_c_d;
      ign_d_q <= ign_d_d;
    end
  end

  assign ign_a = ign_a_q;
  assign ign_b = ign_b_q;
  assign ign_c = ign_c_q;
  assign ign_d = ign_d_q;

  // ---------------- injector pulse timers ----------------
  logic [1:0] inj_q;

  for (genvar g = 0; g < 2; g++) begin : g_inj
    logic [INJ_W-1:0] pw_q, pw_d;
    logic             open_q;

    always_comb begin
      pw_d = pw_q;
      if (!is_synced)                       pw_d = '0;
      else if (evt && idx_q == INJ_POS[g])  pw_d = INJ_PW;   // retrigger reloads
      else if (pw_q != '0)                  pw_d = pw_q - INJ_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pw_q   <= '0;
        open_q <= 1'b0;
      end else begin
        pw_q   <= pw_d;
        open_q <= (pw_d != '0);
      end
    end

    assign inj_q[g] = open_q;
  end

  assign inj_a = inj_q[0];
  assign inj_b = inj_q[1];
endmodule

// File: tb/tb_efi_main_core.sv
module tb_efi_main_core;
  localparam int STALL = 3000;
  localparam int PW    = 100;

  logic clk = 1'b0;
  logic reset, vrin, dm;
  logic ign_a, ign_b, ign_c, ign_d, inj_a, inj_b, synced;

  always #5 clk = ~clk;

  efi_main_core #(.STALL_CYCLES(STALL), .INJ_PW_CYCLES(PW)) dut (
    .clk(clk), .reset(reset), .vrin(vrin), .distributor_mode(dm),
`ifdef EFI_CRANK_GEN_EN
    .fake_crank(1'b0),
`endif
    .ign_a(ign_a), .ign_b(ign_b), .ign_c(ign_c), .ign_d(ign_d),
    .inj_a(inj_a), .inj_b(inj_b), .synced(synced)
  );

  int checks = 0;
  int failures = 0;
  logic [6:0] s3, s4, s5;

  // Pulse monitor: [5]=ign_a [4]=ign_b [3]=ign_c [2]=ign_d [1]=inj_a [0]=inj_b
  logic mon_clr;
  int run[6], wid[6], npul[6];
  always @(negedge clk) begin
    logic [5:0] v;
    v = {ign_a, ign_b, ign_c, ign_d, inj_a, inj_b};
    for (int k = 0; k < 6; k++) begin
      if (mon_clr) begin
        run[k] <= 0; wid[k] <= 0; npul[k] <= 0;
      end else if (v[k]) begin
        run[k] <= run[k] + 1;
      end else if (run[k] > 0) begin
        wid[k] <= run[k]; npul[k] <= npul[k] + 1; run[k] <= 0;
      end
    end
  end

  // {synced, ign_a, ign_b, ign_c, ign_d, inj_a, inj_b}
  function automatic logic [6:0] snap();
    return {synced, ign_a, ign_b, ign_c, ign_d, inj_a, inj_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  // One tooth: 20 clk high then lo clk low. Snapshots after the 3rd, 4th and
  // 5th clock edge following the rise.
  task automatic tooth(input int lo);
    vrin = 1'b1;
    repeat (3) @(posedge clk); #1 s3 = snap();
    @(posedge clk); #1 s4 = snap();
    @(posedge clk); #1 s5 = snap();
    repeat (15) @(posedge clk); #1 vrin = 1'b0;
    repeat (lo) @(posedge clk); #1;
  endtask

  // One revolution, idx 0..57, entered right after a gap.
  task automatic run_rev(input logic dm_v, input logic first);
    dm = dm_v;
    clr_mon();
    for (int i = 0; i < 58; i++) begin
      tooth(i == 57 ? 100 : 20);
      if (i == 0) begin
        chk("sync_e3", s3[6], first ? 32'd0 : 32'd1);
        chk("sync_e4", s4[6], 1);
        chk("inj_a_e4", s4[1], 0);
        chk("inj_a_open", s5[1], 1);
      end
      if (i == 7) begin
        chk("ign_a_dwell_e4", s4[5], 0);
        chk("ign_a_dwell", s5[5], 1);
        chk("ign_c_dwell", s5[3], !dm_v);
      end
      if (i == 10) begin
        chk("ign_a_fire_e4", s4[5], 1);
        chk("ign_a_fire", s5[5], 0);
      end
      if (i == 30) chk("inj_b_open", s5[0], 1);
      if (i == 37) begin
        chk("ign_b_dwell", s5[4], !dm_v);
        chk("ign_d_dwell", s5[2], !dm_v);
        chk("ign_a_2nd_dwell", s5[5], dm_v);
      end
      if (i == 40) begin
        chk("ign_b_fire", s5[4], 0);
        chk("ign_a_2nd_fire", s5[5], 0);
      end
    end
    chk("ign_a_npul", npul[5], dm_v ? 32'd2 : 32'd1);
    chk("ign_a_wid", wid[5], 120);
    chk("ign_b_npul", npul[4], dm_v ? 32'd0 : 32'd1);
    chk("ign_c_npul", npul[3], dm_v ? 32'd0 : 32'd1);
    chk("ign_d_npul", npul[2], dm_v ? 32'd0 : 32'd1);
    chk("inj_a_wid", wid[1], PW);
    chk("inj_b_wid", wid[0], PW);
    chk("inj_a_npul", npul[1], 1);
    chk("synced_hold", synced, 1);
  endtask

  initial begin
    reset = 1'b1; vrin = 1'b0; dm = 1'b0; mon_clr = 1'b0;
    #2 reset = 1'b0;

    // reset held while vrin toggles
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1 vrin = ~vrin;
      if (k == 5) chk("rst_outs_mid", snap(), 0);
    end
    chk("rst_outs", snap(), 0);
    vrin = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // running wheel without a gap: no sync
    for (int k = 0; k < 10; k++) tooth(20);
    chk("nosync_teeth", s5, 0);
    tooth(100);
    chk("nosync_pre_gap", s5, 0);

    // two revolutions: wasted spark then distributor mode
    run_rev(1'b0, 1'b1);
    run_rev(1'b1, 1'b0);

    // missing gap: drop at the non-gap event seen at idx 57
    dm = 1'b0;
    for (int i = 0; i < 59; i++) begin
      tooth(20);
      if (i == 0)  chk("nogap_keep0", s4[6], 1);
      if (i == 57) chk("nogap_keep57", s5[6], 1);
    end
    chk("drop_e3", s3[6], 1);
    chk("drop_e4", s4[6], 0);
    chk("drop_outs", s5, 0);

    // ramped tooth period then a gap: resync on the first gap
    for (int k = 1; k <= 10; k++) tooth(20 + k);
    chk("ramp_nosync", s5[6], 0);
    tooth(130);
    chk("ramp_gap_pre", s5[6], 0);
    tooth(20);
    chk("resync_e3", s3[6], 0);
    chk("resync_e4", s4[6], 1);

    // stall mid-dwell
    for (int i = 1; i <= 8; i++) tooth(20);
    chk("stall_dwell", s5[5], 1);
    repeat (STALL + 4 - 40) @(posedge clk); #1;
    chk("stall_pre_sync", synced, 1);
    chk("stall_pre_ign", ign_a, 1);
    @(posedge clk); #1;
    chk("stall_drop", synced, 0);
    chk("stall_ign_lag", ign_a, 1);
    @(posedge clk); #1;
    chk("stall_outs", snap(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
